// File: rtl/sparse_dense_layer_ctrl.sv
// Fully-connected layer engine for binary-sparse inputs: sums the weight rows selected by a queue of
// active indices onto per-node bias, then shifts, activates and hands the vector out under valid/ready.
module sparse_dense_layer_ctrl #(
  parameter int NODES    = 16,
  parameter int DEPTH    = 784,
  parameter int ADDR_W   = 10,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0,
  parameter int RELU_EN  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         queue_empty,
  input  logic [ADDR_W-1:0]            queue_data,
  output logic                         dequeue,
  output logic                         frame_ack,
  input  logic                         wr_en,
  input  logic                         bias_wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [NODES*WEIGHT_W-1:0]    wr_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NODES*OUT_W-1:0]       out_data,
  output logic                         busy,
  output logic                         addr_err
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, ACT} state_e;

  state_e state_q, state_d;
  logic   start, act_load;
  logic   rd_in_range, wr_in_range, rd_fire;

  logic [NODES*WEIGHT_W-1:0] mem [DEPTH];
  logic [NODES*WEIGHT_W-1:0] rd_row_q;
  logic                      rd_vld_q;
  logic [NODES*WEIGHT_W-1:0] bias_q;

  logic signed [ACC_W-1:0] acc_q [NODES];
  logic signed [ACC_W-1:0] acc_d [NODES];

  logic [NODES*OUT_W-1:0] act_vec;
  logic [NODES*OUT_W-1:0] out_data_q;
  logic                   out_valid_q;
  logic                   frame_ack_q;
  logic                   addr_err_q;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic [WEIGHT_W-1:0] w);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = s[ACC_W-1:0];
    end
  endfunction

  function automatic logic [OUT_W-1:0] activate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] hi;
    v = acc >>> SHIFT;
    activate = v[OUT_W-1:0];
    if (RELU_EN != 0) begin
      hi = v >>> OUT_W;
      if (v[ACC_W-1]) begin
        activate = '0;
      end else if (hi != '0) begin
        activate = '1;
      end
    end else begin
      // In range exactly when every bit above the output sign bit matches it.
      hi = v >>> (OUT_W-1);
      if (hi != '0 && hi != '1) begin
        activate = v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    dequeue  = 1'b0;
    start    = 1'b0;
    act_load = 1'b0;
    case (state_q)
      IDLE: begin
        // frame_ack_q masks the producer's in_valid during the cycle it takes to drop it.
        if (in_valid && !frame_ack_q) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        dequeue = !queue_empty;
        if (queue_empty) state_d = DRAIN;
      end
      DRAIN: state_d = ACT;
      ACT: begin
        if (!out_valid_q || out_ready) begin
          act_load = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_in_range = ({1'b0, queue_data} < DEPTH_L);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_fire     = dequeue && rd_in_range;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE && wr_in_range) begin
      mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_fire) rd_row_q <= mem[queue_data[MEM_AW-1:0]];
  end

  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      acc_d[k] = acc_q[k];
      if (start) begin
        acc_d[k] = ACC_W'($signed(bias_q[k*WEIGHT_W +: WEIGHT_W]));
      end else if (rd_vld_q) begin
        acc_d[k] = sat_add(acc_q[k], rd_row_q[k*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

  always_comb begin
    act_vec = '0;
    for (int k = 0; k < NODES; k++) begin
      act_vec[k*OUT_W +: OUT_W] = activate(acc_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_vld_q    <= 1'b0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_ack_q <= 1'b0;
      addr_err_q  <= 1'b0;
      for (int k = 0; k < NODES; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_fire;
      frame_ack_q <= act_load;
      for (int k = 0; k < NODES; k++) acc_q[k] <= acc_d[k];
      if (bias_wr_en && state_q == IDLE) bias_q <= wr_data;
      if (start) begin
        addr_err_q <= 1'b0;
      end else if (dequeue && !rd_in_range) begin
        addr_err_q <= 1'b1;
      end
      if (act_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= act_vec;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign frame_ack = frame_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q != IDLE);

endmodule
